coreaxitoahbl_wstrb_splitter: RTL and testbench



---
 rtl/coreaxitoahbl_wstrb_splitter.sv | 110 +++++++++++
 tb/tb_coreaxitoahbl_wstrb_splitter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coreaxitoahbl_wstrb_splitter.sv
// Splits one AXI write-strobe beat into naturally aligned, fully enabled AHB transfers.
// Optional macro COREAXITOAHBL_NULL_XFER_EN: an all-zero strobe emits one null descriptor.
module coreaxitoahbl_wstrb_splitter #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_HSIZE  = 3,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int OFS_W      = $clog2(STRB_WIDTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  beatValid,
  output logic                  beatReady,
  input  logic [STRB_WIDTH-1:0] beatStrb,
  input  logic                  beatLast,
  output logic                  xferValid,
  input  logic                  xferReady,
  output logic [OFS_W-1:0]      xferOffset,
  output logic [2:0]            xferSize,
  output logic                  xferBeatEnd,
  output logic                  xferLast,
  output logic                  xferNull
);

  typedef enum logic [0:0] {IDLE, SPLIT} splitState;

  splitState             state, stateNext;
  logic [STRB_WIDTH-1:0] remMask, remNext;
  logic [STRB_WIDTH-1:0] xferMask, candMask;
  logic                  lastFlag, lastNext;
  logic [OFS_W-1:0]      lowIdx;
  logic [2:0]            sizeSel;
  logic                  grow;
  logic                  splitActive, beatEnd, beatTake;

  always_comb begin
    lowIdx = '0;
    for (int i = STRB_WIDTH - 1; i >= 0; i--) begin
      if (remMask[i]) lowIdx = OFS_W'(i);
    end
  end

  // Grow the transfer while it stays naturally aligned and fully enabled.
  always_comb begin
    sizeSel          = '0;
    xferMask         = '0;
    xferMask[lowIdx] = 1'b1;
    candMask         = '0;
    grow             = 1'b1;
    for (int k = 1; k <= MAX_HSIZE; k++) begin
      for (int j = 0; j < STRB_WIDTH; j++) begin
        candMask[j] = (j >= int'(lowIdx)) && (j < int'(lowIdx) + (1 << k));
      end
      if (grow && ((int'(lowIdx) & ((1 << k) - 1)) == 0) &&
          ((remMask & candMask) == candMask)) begin
        sizeSel  = 3'(k);
        xferMask = candMask;
      end else begin
        grow = 1'b0;
      end
    end
  end

  assign splitActive = (state == SPLIT);
  assign beatEnd     = splitActive && ((remMask & ~xferMask) == '0);
  assign beatReady   = ARESETN && (!splitActive || (xferReady && beatEnd));
  assign beatTake    = beatValid && beatReady;

  always_comb begin
    stateNext = state;
    remNext   = remMask;
    lastNext  = lastFlag;
    if (splitActive && xferReady) begin
      remNext = remMask & ~xferMask;
      if (beatEnd) stateNext = IDLE;
    end
    if (beatTake) begin
      remNext  = beatStrb;
      lastNext = beatLast;
`ifdef COREAXITOAHBL_NULL_XFER_EN
      stateNext = SPLIT;
`else
      stateNext = (beatStrb != '0) ? SPLIT : IDLE;
`endif
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= IDLE;
      remMask  <= '0;
      lastFlag <= 1'b0;
    end else begin
      state    <= stateNext;
      remMask  <= remNext;
      lastFlag <= lastNext;
    end
  end

  assign xferValid   = splitActive;
  assign xferOffset  = splitActive ? lowIdx : '0;
  assign xferSize    = splitActive ? sizeSel : '0;
  assign xferBeatEnd = beatEnd;
  assign xferLast    = beatEnd && lastFlag;
`ifdef COREAXITOAHBL_NULL_XFER_EN
  assign xferNull    = splitActive && (remMask == '0);
`else
  assign xferNull    = 1'b0;
`endif

endmodule

// File: tb/tb_coreaxitoahbl_wstrb_splitter.sv
// Bench for coreaxitoahbl_wstrb_splitter: directed plan cases plus random beats against a queue model.
module tb_coreaxitoahbl_wstrb_splitter;

  localparam int DW     = 64;
  localparam int STRB_W = DW / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int MAXH   = 3;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic              beatValid, beatReady, beatLast;
  logic [STRB_W-1:0] beatStrb;
  logic              xferValid, xferReady;
  logic [OFS_W-1:0]  xferOffset;
  logic [2:0]        xferSize;
  logic              xferBeatEnd, xferLast, xferNull;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    int ofs;
    int sz;
    bit bend;
    bit lst;
    bit nul;
  } descT;

  descT expQ[$];

  coreaxitoahbl_wstrb_splitter #(.DATA_WIDTH(DW), .MAX_HSIZE(MAXH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .beatValid(beatValid), .beatReady(beatReady), .beatStrb(beatStrb), .beatLast(beatLast),
    .xferValid(xferValid), .xferReady(xferReady), .xferOffset(xferOffset), .xferSize(xferSize),
    .xferBeatEnd(xferBeatEnd), .xferLast(xferLast), .xferNull(xferNull)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expV);
    nChecks++;
    if (obs !== expV) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expV, $time);
    end
  endtask

  // Reference decomposition: lowest set byte, then the largest aligned all-ones power-of-two run.
  task automatic decompose(input int strb, input bit lst);
    int   r, p, s, n;
    descT d;
    r = strb;
    if (r == 0) begin
`ifdef COREAXITOAHBL_NULL_XFER_EN
      d = '{ofs: 0, sz: 0, bend: 1'b1, lst: lst, nul: 1'b1};
      expQ.push_back(d);
`endif
      return;
    end
    while (r != 0) begin
      p = 0;
      while (((r >> p) & 1) == 0) p++;
      s = 0;
      for (int k = 0; k <= MAXH; k++) begin
        n = 1 << k;
        if ((p % n == 0) && (p + n <= STRB_W) && (((r >> p) & ((1 << n) - 1)) == ((1 << n) - 1)))
          s = k;
      end
      r = r & ~(((1 << (1 << s)) - 1) << p);
      d = '{ofs: p, sz: s, bend: (r == 0), lst: lst && (r == 0), nul: 1'b0};
      expQ.push_back(d);
    end
  endtask

  // Checks current outputs against the model and advances the model for the coming edge.
  task automatic modelCheck();
    bit expBr;
    if (!ARESETN) begin
      chk("rstBeatReady", beatReady, 0);
      expQ.delete();
      return;
    end
    chk("xferValid", xferValid, expQ.size() != 0);
    expBr = (expQ.size() == 0) || (expQ.size() == 1 && xferReady);
    chk("beatReady", beatReady, expBr);
    if (expQ.size() != 0) begin
      chk("xferOffset", xferOffset, expQ[0].ofs);
      chk("xferSize", xferSize, expQ[0].sz);
      chk("xferBeatEnd", xferBeatEnd, expQ[0].bend);
      chk("xferLast", xferLast, expQ[0].lst);
      chk("xferNull", xferNull, expQ[0].nul);
      if (xferReady) void'(expQ.pop_front());
    end
    if (beatValid && expBr) decompose(int'(beatStrb), beatLast);
  endtask

  task automatic apply(input logic bv, input logic [STRB_W-1:0] st, input logic lst, input logic rdy);
    beatValid = bv;
    beatStrb  = st;
    beatLast  = lst;
    xferReady = rdy;
    #1;
    modelCheck();
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [STRB_W-1:0] st;

    ARESETN = 1'b0;
    apply(0, '0, 0, 0);
    tick();
    apply(0, '0, 0, 0);
    chk("rstValid", xferValid, 0);
    chk("rstOffset", xferOffset, 0);
    chk("rstSize", xferSize, 0);
    chk("rstBeatEnd", xferBeatEnd, 0);
    chk("rstLast", xferLast, 0);
    chk("rstNull", xferNull, 0);
    tick();
    ARESETN = 1'b1;

    // Full strobe with last.
    apply(1, 8'hFF, 1, 1);
    chk("ffLatency", xferValid, 0);
    tick();
    apply(0, '0, 0, 1);
    chk("ffOfs", xferOffset, 0);
    chk("ffSize", xferSize, 3);
    chk("ffLast", xferLast, 1);
    tick();

    // 0xFE splits into three transfers.
    apply(1, 8'hFE, 0, 1);
    tick();
    apply(0, '0, 0, 1);
    chk("feOfs0", xferOffset, 1);
    chk("feSize0", xferSize, 0);
    chk("feEnd0", xferBeatEnd, 0);
    tick();
    apply(0, '0, 0, 1);
    chk("feOfs1", xferOffset, 2);
    chk("feSize1", xferSize, 1);
    tick();
    apply(0, '0, 0, 1);
    chk("feOfs2", xferOffset, 4);
    chk("feSize2", xferSize, 2);
    chk("feEnd2", xferBeatEnd, 1);
    chk("feReady2", beatReady, 1);
    tick();

    // Back-to-back beats without a bubble.
    apply(1, 8'hFF, 0, 1);
    tick();
    apply(1, 8'h3C, 0, 1);
    chk("b2bSize0", xferSize, 3);
    chk("b2bReady", beatReady, 1);
    tick();
    apply(0, '0, 0, 1);
    chk("b2bValid1", xferValid, 1);
    chk("b2bOfs1", xferOffset, 2);
    chk("b2bSize1", xferSize, 1);
    tick();
    apply(0, '0, 0, 1);
    chk("b2bOfs2", xferOffset, 4);
    chk("b2bEnd2", xferBeatEnd, 1);
    tick();

    // 0x81 with a stalled consumer.
    apply(1, 8'h81, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(0, '0, 0, 0);
      chk("stallOfs", xferOffset, 0);
      chk("stallValid", xferValid, 1);
      tick();
    end
    apply(0, '0, 0, 1);
    tick();
    apply(0, '0, 0, 1);
    chk("stallOfs7", xferOffset, 7);
    chk("stallLast", xferLast, 1);
    tick();

    // Zero strobe with last.
    apply(1, 8'h00, 1, 1);
    tick();
    apply(0, '0, 0, 1);
`ifdef COREAXITOAHBL_NULL_XFER_EN
    chk("zeroNull", xferNull, 1);
    chk("zeroLast", xferLast, 1);
`else
    chk("zeroValid", xferValid, 0);
`endif
    tick();

    // Reset during the second descriptor of 0x55.
    apply(1, 8'h55, 0, 1);
    tick();
    apply(0, '0, 0, 1);
    tick();
    ARESETN = 1'b0;
    apply(0, '0, 0, 1);
    chk("midOfs", xferOffset, 2);
    tick();
    apply(0, '0, 0, 1);
    chk("midValid", xferValid, 0);
    chk("midReady", beatReady, 0);
    tick();
    ARESETN = 1'b1;
    apply(0, '0, 0, 1);
    chk("postValid", xferValid, 0);
    chk("postReady", beatReady, 1);
    tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      ARESETN = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 4))
        0:       st = '0;
        1:       st = '1;
        2:       st = STRB_W'($urandom) & STRB_W'($urandom);
        default: st = STRB_W'($urandom);
      endcase
      apply(1'($urandom_range(0, 1)), st, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      tick();
    end

    ARESETN = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (expQ.size() == 0) break;
      apply(0, '0, 0, 1);
      tick();
    end
    chk("drainEmpty", expQ.size(), 0);
    apply(0, '0, 0, 1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
